// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer: direction codes, FSM state
// encoding, LFSR seed and the direction-reversal helper.
// Ports: none (package).
package snake_pkg;

   localparam logic [1:0] DIR_L = 2'b00;
   localparam logic [1:0] DIR_R = 2'b01;
   localparam logic [1:0] DIR_U = 2'b10;
   localparam logic [1:0] DIR_D = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_GROW = 2'b10,
      ST_OVER = 2'b11
   } state_t;

   localparam logic [9:0] LFSR_SEED = 10'h2A5;

   // Left/right and up/down differ only in bit 0.
   function automatic logic [1:0] opposite(input logic [1:0] dir);
      return {dir[1], ~dir[0]};
   endfunction

endpackage

// File: rtl/snake_lfsr.sv
// Free-running 10-bit Fibonacci LFSR (taps 10,7) used as the food-cell source.
// Ports: clk, rst_n (async active-low, loads the nonzero seed), value (current state).
// Advances every clock regardless of game state.
module snake_lfsr
   import snake_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) value <= LFSR_SEED;
      else        value <= {value[8:0], value[9] ^ value[6]};
   end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move tick, reversal-filtered direction, length, food, score, game state.
// Ports: clk/rst_n; start, btn_valid/btn_dir, head_pos, body_pos, should_stop in;
//        move_tick, di, len, food_pos, score, game_over, state out.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int                    max_len         = 16,
   parameter int                    num_len         = 10,
   parameter int                    width           = 32,
   parameter int                    height          = 24,
   parameter int                    max_len_bit_len = 4,
   parameter int                    TICK_DIV        = 12_500_000,
   parameter int                    CHECK_DLY       = 2,
   parameter int                    INIT_LEN        = 3,
   parameter logic [num_len-1:0]    FOOD_INIT       = 10'd400
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         btn_valid,
   input  logic [1:0]                   btn_dir,
   input  logic [num_len-1:0]           head_pos,
   input  logic [max_len*num_len-1:0]   body_pos,
   input  logic                         should_stop,
   output logic                         move_tick,
   output logic [1:0]                   di,
   output logic [max_len_bit_len-1:0]   len,
   output logic [num_len-1:0]           food_pos,
   output logic [7:0]                   score,
   output logic                         game_over,
   output logic [1:0]                   state
);

   localparam int                 CNT_W     = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]   CNT_CHECK = CNT_W'(CHECK_DLY);
   localparam logic [num_len:0]   BOARD     = (num_len + 1)'(width * height);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt;
   logic [1:0]             pend_di;
   logic                   grow_first;
   logic                   restart;
   logic                   collide;
   logic                   is_tick;
   logic                   is_check;
   logic                   cand_ok;
   logic [9:0]             lfsr_val;
   logic [num_len-1:0]     cand;

   snake_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .value (lfsr_val)
   );

   assign cand     = num_len'(lfsr_val);
   assign cand_ok  = ({1'b0, cand} < BOARD) && (cand != head_pos);
   assign is_tick  = (state_q == ST_RUN) && (cnt == CNT_LAST);
   assign is_check = (state_q == ST_RUN) && (cnt == CNT_CHECK);

   assign move_tick = is_tick;
   assign game_over = (state_q == ST_OVER);
   assign state     = state_q;

   // Segment 0 is the head itself, so self-collision starts at index 1.
   always_comb begin
      collide = should_stop;
      for (int i = 1; i < max_len; i++) begin
         if (i < int'(len) && head_pos == body_pos[i*num_len +: num_len])
            collide = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      restart = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_RUN;
            restart = 1'b1;
         end
         ST_RUN: if (is_check) begin
            // A collision on the same cycle as reaching food still ends the game.
            if (collide)                   state_d = ST_OVER;
            else if (head_pos == food_pos) state_d = ST_GROW;
         end
         ST_GROW: if (cand_ok) state_d = ST_RUN;
         ST_OVER: if (start) begin
            state_d = ST_RUN;
            restart = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         di         <= DIR_R;
         pend_di    <= DIR_R;
         len        <= max_len_bit_len'(INIT_LEN);
         food_pos   <= FOOD_INIT;
         score      <= 8'd0;
         grow_first <= 1'b0;
      end else begin
         grow_first <= (state_q == ST_RUN) && (state_d == ST_GROW);
         if (restart) begin
            cnt     <= '0;
            di      <= DIR_R;
            pend_di <= DIR_R;
            len     <= max_len_bit_len'(INIT_LEN);
            food_pos <= FOOD_INIT;
            score   <= 8'd0;
         end else if (state_q == ST_RUN) begin
            cnt <= is_tick ? '0 : cnt + 1'b1;
            // Committing only at cnt==0 keeps di stable for a whole move period.
            if (cnt == '0) di <= pend_di;
            // Reversal is judged against the committed direction, not the pending one.
            if (btn_valid && btn_dir != opposite(di)) pend_di <= btn_dir;
         end else if (state_q == ST_GROW) begin
            if (grow_first) begin
               if (int'(len) < max_len - 1) len <= len + 1'b1;
               if (score != 8'hFF)          score <= score + 8'd1;
            end
            if (cand_ok) food_pos <= cand;
         end
      end
   end

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;

   localparam int TD = 8;
   localparam int CD = 2;
   localparam int ML = 16;
   localparam int NL = 10;
   localparam logic [27:0] RST_OBS = {1'b0, 2'b01, 4'd3, 10'd400, 8'd0, 1'b0, 2'b00};

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            btn_valid = 1'b0;
   logic [1:0]      btn_dir = 2'b00;
   logic [NL-1:0]   head_pos = '0;
   logic [ML*NL-1:0] body_pos = '1;
   logic            should_stop = 1'b0;
   logic            move_tick;
   logic [1:0]      di;
   logic [3:0]      len;
   logic [NL-1:0]   food_pos;
   logic [7:0]      score;
   logic            game_over;
   logic [1:0]      state;
   logic [27:0]     obs;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: game mode 0 idle, 1 run, 2 grow, 3 over.
   int         m_st, m_cnt, m_len, m_score;
   logic [1:0] m_di, m_pend;
   logic [9:0] m_food, m_lfsr;
   bit         m_first;

   snake_game_ctrl #(.TICK_DIV(TD), .CHECK_DLY(CD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .btn_valid(btn_valid), .btn_dir(btn_dir),
      .head_pos(head_pos), .body_pos(body_pos), .should_stop(should_stop),
      .move_tick(move_tick), .di(di), .len(len), .food_pos(food_pos), .score(score),
      .game_over(game_over), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {move_tick, di, len, food_pos, score, game_over, state};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_restart();
      m_st = 1; m_cnt = 0; m_len = 3; m_score = 0;
      m_di = 2'b01; m_pend = 2'b01; m_food = 10'd400;
   endtask

   task automatic model_reset();
      model_restart();
      m_st = 0; m_lfsr = 10'h2A5; m_first = 0;
   endtask

   task automatic model_clk();
      logic [9:0] cand;
      logic [1:0] di0, pend0;
      bit hit;
      cand = m_lfsr; di0 = m_di; pend0 = m_pend;
      m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      case (m_st)
         0: if (start) model_restart();
         1: begin
            if (btn_valid && btn_dir != (di0 ^ 2'b01)) m_pend = btn_dir;
            if (m_cnt == 0) m_di = pend0;
            if (m_cnt == CD) begin
               hit = should_stop;
               for (int i = 1; i < m_len; i++)
                  if (body_pos[i*NL +: NL] == head_pos) hit = 1;
               if (hit) m_st = 3;
               else if (head_pos == m_food) begin m_st = 2; m_first = 1; end
            end
            m_cnt = (m_cnt + 1) % TD;
         end
         2: begin
            if (m_first) begin
               if (m_len < ML - 1) m_len++;
               if (m_score < 255) m_score++;
               m_first = 0;
            end
            if (cand < 10'd768 && cand != head_pos) begin m_food = cand; m_st = 1; end
         end
         default: if (start) model_restart();
      endcase
   endtask

   function automatic logic [27:0] model_out();
      logic t;
      t = (m_st == 1) && (m_cnt == TD - 1);
      return {t, m_di, 4'(m_len), m_food, 8'(m_score), (m_st == 3), 2'(m_st)};
   endfunction

   function automatic logic [9:0] safe_head();
      return (m_food == 10'd0) ? 10'd1 : 10'd0;
   endfunction

   task automatic cycle();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_clk();
      @(negedge clk);
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) cycle();
      n_checks++;
      if (obs !== RST_OBS) begin n_fail++; $display("FAIL reset_values: dut=%h want=%h", obs, RST_OBS); end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         btn_valid = 1'($urandom_range(0, 1)); btn_dir = 2'($urandom_range(0, 3));
         head_pos = 10'($urandom_range(0, 767)); should_stop = 1'($urandom_range(0, 1));
         cycle();
         n_checks++;
         if (obs !== model_out()) begin n_fail++; $display("FAIL idle_hold: dut=%h model=%h", obs, model_out()); end
      end
      btn_valid = 0; should_stop = 0; head_pos = safe_head();
   endtask

   task automatic test_tick();
      int ticks = 0;
      start = 1; cycle(); start = 0;
      for (int i = 0; i < 3 * TD; i++) begin
         head_pos = safe_head();
         cycle();
         if (move_tick) ticks++;
         n_checks++;
         if (obs !== model_out()) begin n_fail++; $display("FAIL tick_run: dut=%h model=%h", obs, model_out()); end
      end
      n_checks++;
      if (ticks !== 3) begin n_fail++; $display("FAIL tick_count: got %0d want 3", ticks); end
   endtask

   task automatic test_reset_mid_run();
      int ticks = 0, last = -1, gap_bad = 0;
      for (int i = 0; i < 2 * TD && m_cnt != 5; i++) cycle();
      n_checks++;
      if (m_cnt != 5 || m_st != 1) begin n_fail++; $display("FAIL midrun_align: cnt=%0d st=%0d want 5/1", m_cnt, m_st); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== RST_OBS) begin n_fail++; $display("FAIL midrun_async_reset: dut=%h want=%h", obs, RST_OBS); end
      model_reset();
      cycle();
      rst_n = 1'b1;
      start = 1; cycle(); start = 0;
      for (int i = 0; i < 4 * TD; i++) begin
         head_pos = safe_head();
         cycle();
         if (move_tick) begin
            if (last >= 0 && i - last != TD) gap_bad++;
            last = i; ticks++;
         end
         n_checks++;
         if (obs !== model_out()) begin n_fail++; $display("FAIL midrun_restart: dut=%h model=%h", obs, model_out()); end
      end
      n_checks++;
      if (ticks !== 4 || gap_bad !== 0) begin n_fail++; $display("FAIL midrun_tick_spacing: ticks=%0d bad_gaps=%0d want 4/0", ticks, gap_bad); end
   endtask

   task automatic test_direction();
      for (int i = 0; i < 2 * TD && m_cnt != 1; i++) cycle();
      btn_valid = 1; btn_dir = 2'b00; cycle(); btn_valid = 0;
      cycle();
      for (int i = 0; i < 2 * TD && m_cnt != 1; i++) begin
         cycle();
         n_checks++;
         if (obs !== model_out()) begin n_fail++; $display("FAIL dir_reversal_run: dut=%h model=%h", obs, model_out()); end
      end
      n_checks++;
      if (di !== 2'b01) begin n_fail++; $display("FAIL dir_reversal_ignored: di=%b want 01", di); end
      btn_valid = 1; btn_dir = 2'b10; cycle();
      btn_dir = 2'b11; cycle(); btn_valid = 0;
      for (int i = 0; i < 2 * TD && m_cnt != 1; i++) begin
         cycle();
         n_checks++;
         if (obs !== model_out()) begin n_fail++; $display("FAIL dir_last_wins_run: dut=%h model=%h", obs, model_out()); end
      end
      n_checks++;
      if (di !== 2'b11) begin n_fail++; $display("FAIL dir_last_wins: di=%b want 11", di); end
   endtask

   task automatic test_grow();
      logic [9:0] eat;
      bit seen = 0;
      eat = m_food; head_pos = eat;
      for (int i = 0; i < 60 && !(seen && m_st == 1); i++) begin
         cycle();
         if (m_st == 2) seen = 1;
         n_checks++;
         if (obs !== model_out()) begin n_fail++; $display("FAIL grow_seq: dut=%h model=%h", obs, model_out()); end
      end
      n_checks++;
      if (!seen || state !== 2'b01 || len !== 4'd4 || score !== 8'd1)
      begin n_fail++; $display("FAIL grow_result: state=%b len=%0d score=%0d want 01/4/1", state, len, score); end
      n_checks++;
      if (food_pos >= 10'd768 || food_pos == eat)
      begin n_fail++; $display("FAIL grow_food: food=%0d head=%0d want <768 and !=head", food_pos, eat); end
      head_pos = safe_head();
   endtask

   task automatic test_stop_over();
      int sc;
      sc = m_score;
      head_pos = m_food; should_stop = 1;
      for (int i = 0; i < 2 * TD && m_st != 3; i++) cycle();
      should_stop = 0;
      n_checks++;
      if (state !== 2'b11 || game_over !== 1'b1 || score !== 8'(sc))
      begin n_fail++; $display("FAIL stop_over: state=%b over=%b score=%0d want 11/1/%0d", state, game_over, score, sc); end
      for (int i = 0; i < 100; i++) begin
         btn_valid = 1'($urandom_range(0, 1)); btn_dir = 2'($urandom_range(0, 3));
         cycle();
         n_checks++;
         if (move_tick !== 1'b0 || obs !== model_out())
         begin n_fail++; $display("FAIL over_hold: dut=%h model=%h", obs, model_out()); end
      end
      btn_valid = 0;
   endtask

   task automatic test_body_collide();
      logic [9:0] h;
      start = 1; cycle(); start = 0;
      h = safe_head(); head_pos = h; body_pos = '1; body_pos[1*NL +: NL] = h;
      for (int i = 0; i < 2 * TD && m_st != 3; i++) cycle();
      n_checks++;
      if (state !== 2'b11) begin n_fail++; $display("FAIL body_idx1_collide: state=%b want 11", state); end
      start = 1; cycle(); start = 0;
      body_pos = '1; body_pos[5*NL +: NL] = h;
      for (int i = 0; i < 3 * TD; i++) begin
         cycle();
         n_checks++;
         if (obs !== model_out()) begin n_fail++; $display("FAIL body_idx5_run: dut=%h model=%h", obs, model_out()); end
      end
      n_checks++;
      if (state !== 2'b01) begin n_fail++; $display("FAIL body_idx5_no_collide: state=%b want 01", state); end
      body_pos = '1;
   endtask

   task automatic test_saturation();
      bit seen = 0;
      for (int i = 0; i < 6000 && m_score < 255; i++) begin
         head_pos = m_food;
         cycle();
         n_checks++;
         if (obs !== model_out()) begin n_fail++; $display("FAIL sat_climb: dut=%h model=%h", obs, model_out()); end
      end
      n_checks++;
      if (len !== 4'd15 || score !== 8'd255) begin n_fail++; $display("FAIL sat_reach: len=%0d score=%0d want 15/255", len, score); end
      for (int i = 0; i < 60 && !(seen && m_st == 1); i++) begin
         head_pos = m_food;
         cycle();
         if (m_st == 2) seen = 1;
      end
      n_checks++;
      if (!seen || len !== 4'd15 || score !== 8'd255)
      begin n_fail++; $display("FAIL sat_hold: len=%0d score=%0d want 15/255", len, score); end
      should_stop = 1;
      for (int i = 0; i < 2 * TD && m_st != 3; i++) cycle();
      should_stop = 0;
      start = 1; cycle(); start = 0;
      n_checks++;
      if (state !== 2'b01 || len !== 4'd3 || score !== 8'd0 || di !== 2'b01)
      begin n_fail++; $display("FAIL over_restart: state=%b len=%0d score=%0d di=%b want 01/3/0/01", state, len, score, di); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         btn_valid = ($urandom_range(0, 3) == 0); btn_dir = 2'($urandom_range(0, 3));
         start = ($urandom_range(0, 19) == 0);
         should_stop = ($urandom_range(0, 29) == 0);
         head_pos = ($urandom_range(0, 2) == 0) ? m_food : 10'($urandom_range(0, 767));
         for (int k = 0; k < ML; k++)
            body_pos[k*NL +: NL] = ($urandom_range(0, 15) == 0) ? head_pos : 10'($urandom_range(0, 1023));
         cycle();
         n_checks++;
         if (obs !== model_out()) begin n_fail++; $display("FAIL random_run: dut=%h model=%h", obs, model_out()); end
      end
      start = 0; btn_valid = 0; should_stop = 0;
   endtask

   initial begin
      test_reset();
      test_tick();
      test_reset_mid_run();
      test_direction();
      test_grow();
      test_stop_over();
      test_body_collide();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
